// File: rtl/pl_data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - state_t     : responder FSM state (IDLE accepts, STALL counts wait states)
//   - limits      : legal parameter ranges, checked at elaboration by the top
//   - is_pow2     : helper used by the RAM depth check
package pl_data_memory_responder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BE_W            = WORD_W / 8;
  localparam int unsigned MAX_WAIT_STATES = 15;
  localparam int unsigned MIN_LATENCY     = 1;
  localparam int unsigned MAX_LATENCY     = 8;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/pl_read_latency_pipe.sv
// Fixed-latency read return pipe.
//   clock, reset : clock and asynchronous active-high clear
//   push         : a read was accepted on this edge
//   push_data    : RAM word (or zero for out-of-range) captured at that edge
//   valid, data  : read return, exactly READ_LATENCY edges after the push
// Data stages only load when the stage feeding them is valid, so the output
// word holds its value between valid pulses.
module pl_read_latency_pipe #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic [READ_LATENCY:1]             vld_pipe;
  logic [READ_LATENCY:1][DATA_W-1:0] dat_pipe;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= push;
      if (push) dat_pipe[1] <= push_data;
      for (int s = 2; s <= READ_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign valid = vld_pipe[READ_LATENCY];
  assign data  = dat_pipe[READ_LATENCY];

endmodule

// File: rtl/pl_data_memory_responder.sv
// Data-bus slave memory with configurable wait states and pipelined reads.
//   clock, reset       : single clock, asynchronous active-high reset
//   bus_address        : byte address, bits [1:0] ignored
//   bus_write_data     : lane-aligned write data
//   bus_byte_enable    : per-byte write mask
//   bus_read_enable    : read request
//   bus_write_enable   : write request (wins over a simultaneous read)
//   bus_wait_req       : request cannot be accepted this cycle (combinational)
//   bus_read_data      : read word, held between valid pulses
//   bus_valid          : one-cycle pulse per accepted read
module pl_data_memory_responder
  import pl_data_memory_responder_pkg::*;
#(
  parameter int unsigned WAIT_STATES  = 0,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDRESS = 32'h1001_0000,
  parameter string       INIT_FILE    = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_write_data,
  input  logic [3:0]  bus_byte_enable,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  output logic        bus_wait_req,
  output logic [31:0] bus_read_data,
  output logic        bus_valid
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  if (WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait_states
    $error("WAIT_STATES must be in 0..15");
  end
  if (READ_LATENCY < MIN_LATENCY || READ_LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..8");
  end
  if (!is_pow2(DEPTH_WORDS)) begin : g_bad_depth
    $error("DEPTH_WORDS must be a power of two");
  end

  // Address decode. Addresses below the base would wrap on subtraction,
  // so they are rejected explicitly rather than relying on the index compare.
  logic [31:0]   offset;
  logic          hit;
  logic [AW-1:0] idx;

  assign offset = bus_address - BASE_ADDRESS;
  assign hit    = (bus_address >= BASE_ADDRESS) && ((offset >> 2) < 32'(DEPTH_WORDS));
  assign idx    = offset[AW+1:2];

  // Request / acceptance
  state_t     state;
  logic [3:0] cnt;
  logic       req;
  logic       accept;
  logic       wr_accept;
  logic       rd_accept;

  assign req = bus_read_enable | bus_write_enable;

  always_comb begin
    bus_wait_req = 1'b0;
    if (!reset) begin
      if (state == STALL) bus_wait_req = req & (cnt != 4'd0);
      else                bus_wait_req = req & (WAIT_STATES != 0);
    end
  end

  assign accept    = req & ~bus_wait_req & ~reset;
  assign wr_accept = accept & bus_write_enable;
  assign rd_accept = accept & bus_read_enable & ~bus_write_enable;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req && WAIT_STATES != 0) begin
            state <= STALL;
            cnt   <= WS_LOAD;
          end
        end
        STALL: begin
          // A dropped request is a master error; abandon it without accepting.
          if (!req || cnt == 4'd0) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Word RAM, not reset
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (wr_accept && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (bus_byte_enable[b]) mem[idx][8*b +: 8] <= bus_write_data[8*b +: 8];
      end
    end
  end

  logic [31:0] rd_word;
  assign rd_word = hit ? mem[idx] : 32'h0;

  pl_read_latency_pipe #(
    .READ_LATENCY (READ_LATENCY),
    .DATA_W       (WORD_W)
  ) u_rd_pipe (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_accept),
    .push_data (rd_word),
    .valid     (bus_valid),
    .data      (bus_read_data)
  );

endmodule

// File: tb/tb_pl_data_memory_responder.sv
// Bench for pl_data_memory_responder. Four instances cover the parameter
// sets used: u0 defaults, u1 WS=3/L=2, u2 L=3, u3 L=4.
module tb_pl_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_pulse;
  logic        rst3;
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic [3:0]  be    [4];
  logic        re    [4];
  logic        we    [4];
  logic        wait_req [4];
  logic [31:0] rdata [4];
  logic        valid [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  assign rst3 = rst | rst_pulse;

  pl_data_memory_responder u0 (
    .clock(clk), .reset(rst), .bus_address(addr[0]), .bus_write_data(wdata[0]),
    .bus_byte_enable(be[0]), .bus_read_enable(re[0]), .bus_write_enable(we[0]),
    .bus_wait_req(wait_req[0]), .bus_read_data(rdata[0]), .bus_valid(valid[0]));

  pl_data_memory_responder #(.WAIT_STATES(3), .READ_LATENCY(2)) u1 (
    .clock(clk), .reset(rst), .bus_address(addr[1]), .bus_write_data(wdata[1]),
    .bus_byte_enable(be[1]), .bus_read_enable(re[1]), .bus_write_enable(we[1]),
    .bus_wait_req(wait_req[1]), .bus_read_data(rdata[1]), .bus_valid(valid[1]));

  pl_data_memory_responder #(.READ_LATENCY(3)) u2 (
    .clock(clk), .reset(rst), .bus_address(addr[2]), .bus_write_data(wdata[2]),
    .bus_byte_enable(be[2]), .bus_read_enable(re[2]), .bus_write_enable(we[2]),
    .bus_wait_req(wait_req[2]), .bus_read_data(rdata[2]), .bus_valid(valid[2]));

  pl_data_memory_responder #(.READ_LATENCY(4)) u3 (
    .clock(clk), .reset(rst3), .bus_address(addr[3]), .bus_write_data(wdata[3]),
    .bus_byte_enable(be[3]), .bus_read_enable(re[3]), .bus_write_enable(we[3]),
    .bus_wait_req(wait_req[3]), .bus_read_data(rdata[3]), .bus_valid(valid[3]));

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic r, w, input logic [31:0] a, d,
                              input logic [3:0] b, input logic ev, input logic [31:0] ed);
    vec_t v;
    v.r = r; v.w = w; v.a = a; v.d = d; v.b = b; v.ev = ev; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input int k, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b);
    re[k] = r; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
  endtask

  // Called just after driving a request on u1 at a falling edge. Returns at
  // the acceptance edge with the number of wait cycles observed.
  task automatic req_u1(output int waits, output bit acc);
    waits = 0;
    acc   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!wait_req[1]) begin
        acc = 1'b1;
        break;
      end
      waits++;
      @(negedge clk);
    end
    if (acc) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    bit acc;

    rst = 1'b1;
    rst_pulse = 1'b0;
    for (int k = 0; k < 4; k++) drv(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Default instance: write/read, byte lanes, out-of-range, write-wins
    tbl[0]  = mk(0, 1, 32'h1001_0000, 32'h0123_4567, 4'hF, 0, 32'h0);
    tbl[1]  = mk(0, 1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0);
    tbl[2]  = mk(1, 0, 32'h1001_0004, 32'h0,         4'h0, 1, 32'hDEAD_BEEF);
    tbl[3]  = mk(0, 0, 32'h0,         32'h0,         4'h0, 0, 32'hDEAD_BEEF);
    tbl[4]  = mk(0, 1, 32'h1001_0008, 32'h1122_3344, 4'hF, 0, 32'hDEAD_BEEF);
    tbl[5]  = mk(0, 1, 32'h1001_0008, 32'hAAAA_AAAA, 4'h5, 0, 32'hDEAD_BEEF);
    tbl[6]  = mk(1, 0, 32'h1001_0008, 32'h0,         4'h0, 1, 32'h11AA_33AA);
    tbl[7]  = mk(1, 0, 32'h0000_0000, 32'h0,         4'h0, 1, 32'h0);
    tbl[8]  = mk(1, 0, 32'h1001_4000, 32'h0,         4'h0, 1, 32'h0);
    tbl[9]  = mk(0, 1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 0, 32'h0);
    tbl[10] = mk(0, 1, 32'h1001_4000, 32'h5555_5555, 4'hF, 0, 32'h0);
    tbl[11] = mk(1, 0, 32'h1001_0000, 32'h0,         4'h0, 1, 32'h0123_4567);
    tbl[12] = mk(1, 1, 32'h1001_0004, 32'hCAFE_F00D, 4'hF, 0, 32'h0123_4567);
    tbl[13] = mk(1, 0, 32'h1001_0004, 32'h0,         4'h0, 1, 32'hCAFE_F00D);
    tbl[14] = mk(1, 0, 32'h1000_FFFC, 32'h0,         4'h0, 1, 32'h0);
    tbl[15] = mk(0, 1, 32'h1001_3FFC, 32'h8765_4321, 4'hF, 0, 32'h0);
    tbl[16] = mk(1, 0, 32'h1001_3FFC, 32'h0,         4'h0, 1, 32'h8765_4321);
    tbl[17] = mk(1, 0, 32'h1001_0001, 32'h0,         4'h0, 1, 32'h0123_4567);

    // Reset state
    @(posedge clk); #1;
    chk("rst_wait_u0",  32'(wait_req[0]), 32'h0);
    chk("rst_valid_u0", 32'(valid[0]),    32'h0);
    chk("rst_rdata_u0", rdata[0],         32'h0);
    chk("rst_rdata_u3", rdata[3],         32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table on u0: every row is accepted in its own cycle
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drv(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b);
      #1;
      chk($sformatf("vec%0d_wait", i), 32'(wait_req[0]), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 32'(valid[0]), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_rdata", i), rdata[0], tbl[i].ed);
    end
    @(negedge clk);
    drv(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // WS=3, L=2: write then read with stall counting
    @(negedge clk);
    drv(1, 1'b0, 1'b1, 32'h1001_0004, 32'h0BAD_F00D, 4'hF);
    req_u1(waits, acc);
    chk("t2_wr_waits",  32'(waits), 32'd3);
    chk("t2_wr_accept", 32'(acc),   32'd1);
    #1;
    chk("t2_wr_novalid", 32'(valid[1]), 32'h0);
    @(negedge clk);
    drv(1, 1'b1, 1'b0, 32'h1001_0004, 32'h0, 4'h0);
    req_u1(waits, acc);
    chk("t2_rd_waits",  32'(waits), 32'd3);
    chk("t2_rd_accept", 32'(acc),   32'd1);
    #1;
    chk("t2_rd_early", 32'(valid[1]), 32'h0);
    @(negedge clk);
    drv(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    chk("t2_rd_valid", 32'(valid[1]), 32'h1);
    chk("t2_rd_data",  rdata[1],      32'h0BAD_F00D);
    @(posedge clk); #1;
    chk("t2_rd_pulse", 32'(valid[1]), 32'h0);
    chk("t2_rd_hold",  rdata[1],      32'h0BAD_F00D);

    // L=3: four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drv(2, 1'b0, 1'b1, 32'h1001_0010 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 4) drv(2, 1'b1, 1'b0, 32'h1001_0010 + 32'(4 * k), 32'h0, 4'h0);
      else       drv(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #1;
      if (k < 4) chk($sformatf("t4_wait%0d", k), 32'(wait_req[2]), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("t4_valid%0d", k), 32'(valid[2]), 32'((k >= 2) && (k <= 5)));
      if (k >= 2 && k <= 5)
        chk($sformatf("t4_data%0d", k), rdata[2], 32'hA000_0000 + 32'(k - 2));
    end

    // L=4: complete one read, then reset with two reads in flight
    @(negedge clk);
    drv(3, 1'b0, 1'b1, 32'h1001_0000, 32'h5A5A_5A5A, 4'hF);
    @(negedge clk);
    drv(3, 1'b1, 1'b0, 32'h1001_0000, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t6_pre_valid%0d", k), 32'(valid[3]), 32'(k == 3));
      @(negedge clk);
      if (k == 0) drv(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    chk("t6_pre_data", rdata[3], 32'h5A5A_5A5A);
    drv(3, 1'b1, 1'b0, 32'h1001_0000, 32'h0, 4'h0);
    @(negedge clk);
    drv(3, 1'b1, 1'b0, 32'h1001_0000, 32'h0, 4'h0);
    @(negedge clk);
    drv(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #2;
    rst_pulse = 1'b1;
    #1;
    chk("t6_async_valid", 32'(valid[3]),    32'h0);
    chk("t6_async_rdata", rdata[3],         32'h0);
    chk("t6_async_wait",  32'(wait_req[3]), 32'h0);
    @(negedge clk);
    rst_pulse = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t6_post_valid%0d", k), 32'(valid[3]), 32'h0);
    end
    chk("t6_post_rdata", rdata[3], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
